de1_blinker_mem_checker: RTL and testbench

//  Avalon-MM master that exercises the on-chip memory slave from the initiator side.
//  On start it fills a word region with an index-derived pattern, then reads the region back.

---
 rtl/de1_blinker_mem_checker.sv | 198 +++++++++++++++++++
 tb/tb_de1_blinker_mem_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/de1_blinker_mem_checker.sv
// rtl/de1_blinker_mem_checker.sv - Avalon-MM master that writes a pattern region and verifies it on read-back
module de1_blinker_mem_checker #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] base_q, base_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [31:0]       seed_q, seed_n;
    logic [CNT_W-1:0]  idx_q, idx_n;
    logic [CNT_W-1:0]  idx_inc, last_idx;

    logic              busy_n, done_n, pass_n;
    logic [CNT_W-1:0]  err_n, err_next;
    logic [ADDR_W-1:0] fea_n;
    logic [ADDR_W-1:0] addr_n;
    logic              read_n, write_n;
    logic [31:0]       wdata_n;
    logic [3:0]        be_n;
    logic              mismatch;

    function automatic logic [31:0] pattern_of(input logic [CNT_W-1:0] idx, input logic [31:0] s);
        logic [31:0] w;
        w = 32'(idx);
        return {w[15:0], ~w[15:0]} ^ s;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] idx);
        return {b[ADDR_W-1:2], 2'b00} + ADDR_W'({idx, 2'b00});
    endfunction

    assign idx_inc  = idx_q + CNT_W'(1);
    assign last_idx = cnt_q - CNT_W'(1);
    assign mismatch = (avm_readdata != pattern_of(idx_q, seed_q));

    // Every output has a *_n twin so the bus side is driven straight from flops.
    always_comb begin
        state_n  = state;
        base_n   = base_q;
        cnt_n    = cnt_q;
        seed_n   = seed_q;
        idx_n    = idx_q;
        busy_n   = busy;
        done_n   = done;
        pass_n   = pass;
        err_n    = err_count;
        err_next = err_count;
        fea_n    = first_err_addr;
        addr_n   = avm_address;
        read_n   = avm_read;
        write_n  = avm_write;
        wdata_n  = avm_writedata;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_n = base_addr;
                    cnt_n  = word_count;
                    seed_n = seed;
                    idx_n  = '0;
                    err_n  = '0;
                    fea_n  = '0;
                    done_n = 1'b0;
                    pass_n = 1'b0;
                    if (word_count == '0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = S_WRITE;
                        busy_n  = 1'b1;
                        write_n = 1'b1;
                        addr_n  = addr_of(base_addr, '0);
                        wdata_n = pattern_of('0, seed);
                    end
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    if (idx_q == last_idx) begin
                        idx_n   = '0;
                        write_n = 1'b0;
                        state_n = S_RD_REQ;
                    end else begin
                        idx_n   = idx_inc;
                        addr_n  = addr_of(base_q, idx_inc);
                        wdata_n = pattern_of(idx_inc, seed_q);
                    end
                end
            end
            S_RD_REQ: begin
                // First cycle in this state raises the request; later cycles wait for acceptance.
                if (!avm_read) begin
                    read_n = 1'b1;
                    addr_n = addr_of(base_q, idx_q);
                end else if (!avm_waitrequest) begin
                    read_n  = 1'b0;
                    state_n = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    if (mismatch) begin
                        if (err_count == '0) begin
                            fea_n = addr_of(base_q, idx_q);
                        end
                        if (err_count != '1) begin
                            err_next = err_count + CNT_W'(1);
                        end
                    end
                    err_n = err_next;
                    if (idx_q == last_idx) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_next == '0);
                    end else begin
                        idx_n   = idx_inc;
                        state_n = S_RD_REQ;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        be_n = (read_n || write_n) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            base_q         <= '0;
            cnt_q          <= '0;
            seed_q         <= '0;
            idx_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= 4'h0;
        end else begin
            state          <= state_n;
            base_q         <= base_n;
            cnt_q          <= cnt_n;
            seed_q         <= seed_n;
            idx_q          <= idx_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_err_addr <= fea_n;
            avm_address    <= addr_n;
            avm_read       <= read_n;
            avm_write      <= write_n;
            avm_writedata  <= wdata_n;
            avm_byteenable <= be_n;
        end
    end

endmodule

// File: tb/tb_de1_blinker_mem_checker.sv
// tb/tb_de1_blinker_mem_checker.sv - directed and randomized bench with a memory slave model
module tb_de1_blinker_mem_checker;

    localparam int ADDR_W = 18;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic [31:0]       seed;
    logic              busy, done, pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read, avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest   = 1'b0;
    logic [31:0]       avm_readdata      = 32'h0;
    logic              avm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    de1_blinker_mem_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .word_count       (word_count),
        .seed             (seed),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_err_addr   (first_err_addr),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_byteenable   (avm_byteenable),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int checks = 0;
    int errors = 0;

    bit [31:0]         mem [0:(1<<(ADDR_W-2))-1];
    int                lat = 1;
    bit                stall_en = 1'b0;
    bit                corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;
    bit                pending = 1'b0;
    int                pend_cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic [ADDR_W-1:0] rd_addr_q [$];
    int                viol = 0;
    bit                snap_valid = 1'b0;
    logic [55:0]       snap = '0;

    // Slave side: accept on posedge, answer on negedge after lat cycles.
    always @(posedge clk) begin
        if (reset) begin
            snap_valid = 1'b0;
        end else begin
            if (snap_valid && ({avm_address, avm_writedata, avm_read, avm_write, avm_byteenable} !== snap))
                viol++;
            if (avm_read && avm_write)
                viol++;
            if (avm_byteenable !== ((avm_read || avm_write) ? 4'hF : 4'h0))
                viol++;
            if (avm_write && !avm_waitrequest) begin
                mem[avm_address[ADDR_W-1:2]] = avm_writedata;
                wr_addr_q.push_back(avm_address);
                wr_data_q.push_back(avm_writedata);
            end
            if (avm_read && !avm_waitrequest) begin
                pending   = 1'b1;
                pend_cnt  = lat;
                pend_addr = avm_address;
                rd_addr_q.push_back(avm_address);
            end
            snap_valid = (avm_read || avm_write) && avm_waitrequest;
            snap       = {avm_address, avm_writedata, avm_read, avm_write, avm_byteenable};
        end
    end

    always @(negedge clk) begin
        avm_waitrequest   = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        avm_readdatavalid = 1'b0;
        if (pending) begin
            if (pend_cnt <= 1) begin
                pending           = 1'b0;
                avm_readdatavalid = 1'b1;
                avm_readdata      = (corrupt_en && pend_addr == corrupt_addr) ? 32'h0
                                                                             : mem[pend_addr[ADDR_W-1:2]];
            end else begin
                pend_cnt--;
            end
        end
    end

    function automatic logic [31:0] ref_pattern(input int i, input logic [31:0] s);
        logic [15:0] k;
        k = i[15:0];
        return {k, ~k} ^ s;
    endfunction

    function automatic logic [ADDR_W-1:0] ref_addr(input logic [ADDR_W-1:0] b, input int i);
        logic [31:0] a;
        a = 32'(b & ~18'h3) + 32'(4 * i);
        return a[ADDR_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n, input logic [31:0] s,
                       input int glitch_at, output int cycles);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        @(negedge clk);
        base_addr  = b;
        word_count = n;
        seed       = s;
        start      = 1'b1;
        cycles     = 0;
        while (cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) start = 1'b0;
            if (cycles == glitch_at) begin
                start      = 1'b1;
                base_addr  = ADDR_W'($urandom);
                word_count = CNT_W'($urandom);
                seed       = $urandom;
            end
            if (cycles == glitch_at + 1) start = 1'b0;
            if (done) break;
        end
        check("run_done", done, 1'b1);
    endtask

    task automatic verify(input string tag, input logic [ADDR_W-1:0] b, input int n, input logic [31:0] s);
        int errs, wbad, rbad;
        logic [ADDR_W-1:0] fea;
        errs = 0; wbad = 0; rbad = 0; fea = '0;
        for (int i = 0; i < n; i++) begin
            if (corrupt_en && ref_addr(b, i) == corrupt_addr && ref_pattern(i, s) != 32'h0) begin
                if (errs == 0) fea = ref_addr(b, i);
                errs++;
            end
            if (i < wr_addr_q.size() && (wr_addr_q[i] !== ref_addr(b, i) || wr_data_q[i] !== ref_pattern(i, s)))
                wbad++;
            if (i < rd_addr_q.size() && rd_addr_q[i] !== ref_addr(b, i))
                rbad++;
        end
        check({tag, "_wr_count"}, wr_addr_q.size(), n);
        check({tag, "_wr_seq"}, wbad, 0);
        check({tag, "_rd_count"}, rd_addr_q.size(), n);
        check({tag, "_rd_seq"}, rbad, 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pass"}, pass, (errs == 0));
        check({tag, "_err_count"}, err_count, errs);
        check({tag, "_first_err"}, first_err_addr, fea);
        check({tag, "_bus_rules"}, viol, 0);
    endtask

    function automatic logic [127:0] all_outs();
        return {busy, done, pass, err_count, first_err_addr, avm_address,
                avm_read, avm_write, avm_writedata, avm_byteenable};
    endfunction

    initial begin
        int cyc, guard, n;
        logic [ADDR_W-1:0] b;
        logic [31:0] s;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'h0);
        reset = 1'b0;

        lat = 1;
        run(18'h100, 16'd4, 32'h0, 0, cyc);
        verify("t1", 18'h100, 4, 32'h0);
        check("t1_done", done, 1'b1);
        check("t1_wd0", wr_data_q[0], 32'h0000FFFF);
        check("t1_wd1", wr_data_q[1], 32'h0001FFFE);
        check("t1_wd2", wr_data_q[2], 32'h0002FFFD);
        check("t1_wd3", wr_data_q[3], 32'h0003FFFC);
        check("t1_wa3", wr_addr_q[3], 18'h10C);
        check("t1_cycles", cyc, 1 + 4 + 3 * 4);

        corrupt_en = 1'b1; corrupt_addr = 18'h108;
        run(18'h100, 16'd4, 32'h0, 0, cyc);
        verify("t2", 18'h100, 4, 32'h0);
        check("t2_err_count", err_count, 16'd1);
        check("t2_first_err", first_err_addr, 18'h108);
        check("t2_pass", pass, 1'b0);
        corrupt_en = 1'b0;

        stall_en = 1'b1; lat = $urandom_range(1, 3);
        b = ADDR_W'($urandom); s = $urandom;
        run(b, 16'd64, s, 0, cyc);
        verify("t3", b, 64, s);
        stall_en = 1'b0; lat = 1;

        run(18'h200, 16'd0, 32'h1234, 0, cyc);
        verify("t4", 18'h200, 0, 32'h1234);
        check("t4_cycles", cyc, 1);
        check("t4_pass", pass, 1'b1);

        lat = 3;
        @(negedge clk);
        base_addr = 18'h400; word_count = 16'd8; seed = 32'hA5A5_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!avm_read && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t5_reached_read", avm_read, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_reset_outputs", all_outs(), 128'h0);
        repeat (4) @(negedge clk);
        check("t5_late_rdv_outputs", all_outs(), 128'h0);
        lat = 1;
        b = ADDR_W'($urandom); s = $urandom;
        run(b, 16'd8, s, 0, cyc);
        verify("t5_rerun", b, 8, s);

        s = $urandom;
        run(18'h3FFFC, 16'd2, s, 3, cyc);
        verify("t6", 18'h3FFFC, 2, s);
        check("t6_wa0", wr_addr_q[0], 18'h3FFFC);
        check("t6_wa1_wrap", wr_addr_q[1], 18'h00000);

        for (int k = 0; k < 4; k++) begin
            b = ADDR_W'($urandom); s = $urandom; n = $urandom_range(1, 24);
            stall_en = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 4);
            corrupt_en = 1'($urandom_range(0, 1));
            corrupt_addr = ref_addr(b, $urandom_range(0, n - 1));
            run(b, CNT_W'(n), s, 0, cyc);
            verify($sformatf("t7_%0d", k), b, n, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
